spi_slave_phy: RTL

SPI mode-3 (CPOL=1, CPHA=1) responder physical layer: the device-side counterpart to the cartridge SD-card SPI master. It oversamples the external SPI pins in the `clk_i` domain, deserialises MOSI into bytes and serialises MISO from a one-byte holding register. It is used as the SD-card side of the loopback/emulation path and in board-to-board debug links.

---
 rtl/spi_slave_phy.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/spi_slave_phy.sv
// SPI mode-3 responder PHY. It oversamples the SPI pins in clk_i, deserialises MOSI and serialises MISO from a one-byte holding register.
// Define SPI_SLAVE_PHY_SYNC3_EN to get 3-FF input synchronisers. The default build uses 2-FF synchronisers.
module spi_slave_phy #(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = 8'hFF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  spi_clk_i,
   input  logic                  spi_ncs_i,
   input  logic                  spi_mosi_i,
   output logic                  spi_miso_o,
   output logic                  spi_miso_en_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_load_i,
   output logic                  tx_ready_o,
   output logic                  tx_underrun_o,
   output logic                  frame_active_o,
   output logic                  frame_start_o,
   output logic                  frame_end_o
);

`ifdef SPI_SLAVE_PHY_SYNC3_EN
   localparam int SYNC_STAGES = 3;
`else
   localparam int SYNC_STAGES = 2;
`endif
   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  clk_sync, ncs_sync, mosi_sync;
   logic                    clk_d, ncs_d;
   logic                    clk_s, ncs_s, mosi_s;
   logic                    clk_rise, clk_fall, ncs_rise, ncs_fall;
   logic                    tx_event, rx_event, reload, load_ok;
   logic [CNT_W-1:0]        bit_cnt;
   logic [DATA_WIDTH-1:0]   rx_shift, tx_shift, hold_data;
   logic                    hold_empty;

   // Stages reset high to match an idle bus (clock high, nCS deasserted).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clk_sync  <= '1;
         ncs_sync  <= '1;
         mosi_sync <= '1;
         clk_d     <= 1'b1;
         ncs_d     <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk_i};
         ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi_ncs_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         clk_d     <= clk_s;
         ncs_d     <= ncs_s;
      end
   end

   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign ncs_s    = ncs_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign clk_rise = ~clk_d & clk_s;
   assign clk_fall = clk_d & ~clk_s;
   assign ncs_rise = ~ncs_d & ncs_s;
   assign ncs_fall = ncs_d & ~ncs_s;

   // An nCS edge masks any spi_clk edge detected in the same cycle.
   assign tx_event = (state_q == ACTIVE) && !ncs_rise && !ncs_fall && clk_fall;
   assign rx_event = (state_q == ACTIVE) && !ncs_rise && !ncs_fall && clk_rise;
   assign reload   = ((state_q == IDLE) && ncs_fall) || (rx_event && (bit_cnt == LAST_BIT));
   assign load_ok  = tx_load_i && hold_empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ncs_fall) state_d = ACTIVE;
         ACTIVE:  if (ncs_rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         spi_miso_o    <= 1'b1;
         spi_miso_en_o <= 1'b0;
         rx_data_o     <= '0;
         rx_valid_o    <= 1'b0;
         tx_underrun_o <= 1'b0;
         frame_start_o <= 1'b0;
         frame_end_o   <= 1'b0;
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         hold_data     <= '0;
         hold_empty    <= 1'b1;
      end else begin
         rx_valid_o    <= 1'b0;
         tx_underrun_o <= 1'b0;
         frame_start_o <= 1'b0;
         frame_end_o   <= 1'b0;

         if ((state_q == IDLE) && ncs_fall) begin
            frame_start_o <= 1'b1;
            bit_cnt       <= '0;
            spi_miso_en_o <= 1'b1;
            spi_miso_o    <= 1'b1;
         end else if ((state_q == ACTIVE) && ncs_rise) begin
            frame_end_o   <= 1'b1;
            spi_miso_en_o <= 1'b0;
            spi_miso_o    <= 1'b1;
            bit_cnt       <= '0;
            rx_shift      <= '0;
         end else if (tx_event) begin
            spi_miso_o <= tx_shift[DATA_WIDTH-1];
            tx_shift   <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
         end else if (rx_event) begin
            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt    <= '0;
               rx_data_o  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
               rx_valid_o <= 1'b1;
            end
         end

         // The reload reads the holding register before any same-cycle load.
         if (reload) begin
            tx_shift      <= hold_empty ? FILL_BYTE : hold_data;
            tx_underrun_o <= hold_empty;
            hold_empty    <= 1'b1;
         end
         if (load_ok) begin
            hold_data  <= tx_data_i;
            hold_empty <= 1'b0;
         end
      end
   end

   assign tx_ready_o     = hold_empty;
   assign frame_active_o = (state_q == ACTIVE);

endmodule
